// File: rtl/result_tx_pkg.sv
// Shared types and constants for the result UART transmitter.
// The FSM state encoding and frame geometry live here so the datapath and any checkers agree.
package result_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned FRAME_DATA_BITS = 8;
  localparam logic [2:0]  LAST_BIT_IDX    = 3'(FRAME_DATA_BITS - 1);

  function automatic logic [7:0] frame_count_inc(input logic [7:0] count);
    return count + 8'd1;
  endfunction

endpackage

// File: rtl/result_uart_tx_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each serial bit.
// restart pins the count at zero so the first bit of a frame always gets a full period.
module baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_done
);

  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

  logic [7:0] cnt_d;
  logic [7:0] cnt_q;

  // next count: wrap at the bit boundary or hold at zero while restarted
  always_comb begin
    if (restart || (cnt_q == LAST_CNT)) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_done = !restart && (cnt_q == LAST_CNT);

endmodule

// File: rtl/result_uart_tx.sv
// 8N1 serial transmitter for adder results with a 1-entry holding buffer.
// A buffered byte enters START straight from STOP, so queued frames go out with no idle gap.
module result_uart_tx
  import result_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic [7:0] frame_count
);

  tx_state_e  state_d,     state_q;
  logic [7:0] buf_d,       buf_q;
  logic       buf_full_d,  buf_full_q;
  logic [7:0] shift_d,     shift_q;
  logic [2:0] bit_idx_d,   bit_idx_q;
  logic       tx_d,        tx_q;
  logic       busy_d,      busy_q;
  logic [7:0] frame_cnt_d, frame_cnt_q;

  logic accept_s;
  logic bit_done_s;
  logic baud_restart_s;

  assign accept_s       = in_valid && !buf_full_q;
  assign baud_restart_s = (state_q == ST_IDLE);

  baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .restart  (baud_restart_s),
    .bit_done (bit_done_s)
  );

  // next-state, buffer and registered-output logic
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;

    // accept and drain are mutually exclusive: one needs the buffer empty, the other full
    if (accept_s) begin
      buf_d      = in_data;
      buf_full_d = 1'b1;
    end else begin
      buf_d      = buf_q;
    end

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (buf_full_q) begin
          shift_d    = buf_q;
          buf_full_d = 1'b0;
          bit_idx_d  = 3'd0;
          state_d    = ST_START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_done_s) begin
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = 3'd0;
        end else begin
          state_d   = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_done_s && (bit_idx_q == LAST_BIT_IDX)) begin
          state_d   = ST_STOP;
          tx_d      = 1'b1;
          bit_idx_d = 3'd0;
        end else if (bit_done_s) begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          state_d   = ST_DATA;
        end
      end
      ST_STOP: begin
        if (bit_done_s) begin
          frame_cnt_d = frame_count_inc(frame_cnt_q);
          if (buf_full_q) begin
            shift_d    = buf_q;
            buf_full_d = 1'b0;
            state_d    = ST_START;
            tx_d       = 1'b0;
            busy_d     = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            tx_d       = 1'b1;
            busy_d     = 1'b0;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        buf_full_d = 1'b0;
        bit_idx_d  = 3'd0;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  // state, datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      buf_q       <= 8'd0;
      buf_full_q  <= 1'b0;
      shift_q     <= 8'd0;
      bit_idx_q   <= 3'd0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign in_ready    = !buf_full_q;
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Scoreboard bench for result_uart_tx: accepted bytes are queued and matched against
// frames decoded cycle-by-cycle from the tx line.
module tb_result_uart_tx;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 10 * CPB;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [7:0] frame_count;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;

  logic [7:0] sb[$];
  int         starts[$];
  logic [7:0] exp_fc;

  result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .tx          (tx),
    .busy        (busy),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FRAME_CYC-1:0] frame_pattern(input logic [7:0] b);
    logic [9:0] bits;
    logic [FRAME_CYC-1:0] pat;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < FRAME_CYC; i++) pat[i] = bits[i / CPB];
    return pat;
  endfunction

  // tx line monitor: collects FRAME_CYC samples per frame, one per cycle
  initial begin : monitor
    logic [FRAME_CYC-1:0] smp;
    logic [7:0]           eb;
    int                   k;
    bit                   active;
    bit                   pend;
    active = 0; pend = 0; k = 0; exp_fc = 8'd0; smp = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 0; pend = 0; k = 0;
        sb.delete(); starts.delete();
        exp_fc = 8'd0;
      end else begin
        if (pend) begin
          check_val("frame_count", {56'd0, frame_count}, {56'd0, exp_fc});
          pend = 0;
        end
        if (!active) begin
          if (tx == 1'b0) begin
            active = 1; smp[0] = tx; k = 1;
            starts.push_back(cyc);
          end
        end else begin
          smp[k] = tx;
          k++;
          if (k == FRAME_CYC) begin
            active = 0; pend = 1;
            exp_fc = exp_fc + 8'd1;
            if (sb.size() == 0) begin
              check_val("unexpected_frame", {24'd0, smp}, 64'd0);
            end else begin
              eb = sb.pop_front();
              check_val("frame_shape", {24'd0, smp}, {24'd0, frame_pattern(eb)});
            end
          end
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // offer a byte; with scramble set, in_data changes every cycle the handshake stalls
  task automatic send_byte(input logic [7:0] b, input bit scramble, output int acc);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = scramble ? 8'($urandom_range(0, 255)) : b;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
      if (scramble) in_data = 8'($urandom_range(0, 255));
    end
    if (!in_ready) begin
      check_val("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      acc = cyc;
    end else begin
      @(posedge clk);
      sb.push_back(in_data);
      @(negedge clk);
      acc = cyc;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(busy == 1'b0 && in_ready == 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check_val("idle_timeout", 64'd0, 64'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin : main
    int acc, acc2, hi;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'd0;
    #1;
    check_val("rst_tx", {63'd0, tx}, 64'd1);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_ready", {63'd0, in_ready}, 64'd1);
    check_val("rst_fc", {56'd0, frame_count}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // single byte with exact latency
    send_byte(8'hA5, 1'b0, acc);
    check_val("t1_tx_before", {63'd0, tx}, 64'd1);
    @(negedge clk);
    check_val("t1_tx_start", {63'd0, tx}, 64'd0);
    check_val("t1_busy_start", {63'd0, busy}, 64'd1);
    while (cyc < acc + 40) @(negedge clk);
    check_val("t1_busy_last", {63'd0, busy}, 64'd1);
    check_val("t1_tx_stop", {63'd0, tx}, 64'd1);
    @(negedge clk);
    check_val("t1_busy_end", {63'd0, busy}, 64'd0);
    check_val("t1_fc", {56'd0, frame_count}, 64'd1);
    check_val("t1_nstarts", 64'(starts.size()), 64'd1);
    if (starts.size() > 0) check_val("t1_latency", 64'(starts[0] - acc), 64'd1);
    wait_idle();

    // back-to-back frames
    apply_reset();
    send_byte(8'h03, 1'b0, acc);
    send_byte(8'h0F, 1'b0, acc2);
    check_val("t2_ready_full", {63'd0, in_ready}, 64'd0);
    wait_idle();
    check_val("t2_fc", {56'd0, frame_count}, 64'd2);
    check_val("t2_nstarts", 64'(starts.size()), 64'd2);
    if (starts.size() >= 2) check_val("t2_spacing", 64'(starts[1] - starts[0]), 64'd40);

    // backpressure with scrambled data while stalled
    for (int i = 0; i < 5; i++) send_byte(8'h00, 1'b1, acc);
    wait_idle();

    // reset during data bit 3 of 0x55
    apply_reset();
    send_byte(8'h55, 1'b0, acc);
    while (cyc < acc + 18) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("t4_tx", {63'd0, tx}, 64'd1);
    check_val("t4_busy", {63'd0, busy}, 64'd0);
    check_val("t4_ready", {63'd0, in_ready}, 64'd1);
    check_val("t4_fc", {56'd0, frame_count}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    hi = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx === 1'b1 && busy === 1'b0) hi++;
    end
    check_val("t4_no_residual", 64'(hi), 64'd60);
    send_byte(8'h3C, 1'b0, acc);
    wait_idle();
    check_val("t4_fc_after", {56'd0, frame_count}, 64'd1);

    // 256 frames of 0x00: counter wraps, every frame 40 cycles
    apply_reset();
    for (int i = 0; i < 256; i++) send_byte(8'h00, 1'b0, acc);
    wait_idle();
    check_val("t5_fc_wrap", {56'd0, frame_count}, 64'd0);
    check_val("t5_nstarts", 64'(starts.size()), 64'd256);
    for (int i = 1; i < starts.size(); i++)
      check_val("t5_spacing", 64'(starts[i] - starts[i-1]), 64'd40);

    check_val("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
